// File: rtl/whack_judge.sv
// Whack-a-mole judge: conditions five raw buttons, scores hits against the mole
// position, counts misses and runs the IDLE/PLAY/HOLD/OVER game state machine.
module whack_judge #(
    parameter int              DEBOUNCE_CYCLES = 1000,
    parameter longint unsigned GAME_CYCLES     = 30000,
    parameter int              MAX_MISSES      = 3,
    parameter int              HOLD_CYCLES     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_btn,
    input  logic       i_start,
    input  logic [2:0] i_mole_position,
    output logic       o_change_position,
    output logic [3:0] o_score_tens,
    output logic [3:0] o_score_ones,
    output logic [1:0] o_misses,
    output logic [1:0] o_state,
    output logic       o_hit_flash
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [31:0]       TIMER_LAST = 32'(GAME_CYCLES - 1);
    localparam logic [1:0]        MISS_MAX   = 2'(MAX_MISSES);

    logic [4:0]      r_btn_p0;
    logic [4:0]      r_btn_p1;
    logic [4:0]      r_deb_p2;
    logic [4:0]      r_deb_p3;
    logic [4:0]      r_press_p4;
    logic [DB_W-1:0] r_db_cnt [5];

    logic [1:0]        r_state;
    logic [3:0]        r_score_tens;
    logic [3:0]        r_score_ones;
    logic [1:0]        r_misses;
    logic [31:0]       r_timer;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_change;
    logic              r_hit_flash;

    logic [4:0] w_mole_mask;
    logic       w_hit;
    logic       w_any_press;
    logic       w_timer_end;
    logic [1:0] w_miss_next;
    logic [7:0] w_score_next;

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
        if (bcd == 8'h99)
            return bcd;
        else if (bcd[3:0] == 4'd9)
            return {bcd[7:4] + 4'd1, 4'd0};
        else
            return {bcd[7:4], bcd[3:0] + 4'd1};
    endfunction

    // Stage p0/p1: synchronizer; p2: debounced level; p3/p4: rising-edge pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_p0   <= '0;
            r_btn_p1   <= '0;
            r_deb_p2   <= '0;
            r_deb_p3   <= '0;
            r_press_p4 <= '0;
            for (int k = 0; k < 5; k++) r_db_cnt[k] <= '0;
        end else begin
            r_btn_p0   <= i_btn;
            r_btn_p1   <= r_btn_p0;
            r_deb_p3   <= r_deb_p2;
            r_press_p4 <= r_deb_p2 & ~r_deb_p3;
            for (int k = 0; k < 5; k++) begin
                if (r_btn_p1[k] == r_deb_p2[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_deb_p2[k] <= r_btn_p1[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Positions 5-7 produce an empty mask, so any press there is a miss.
    assign w_mole_mask  = (i_mole_position <= 3'd4) ? (5'd1 << i_mole_position) : 5'd0;
    assign w_hit        = |(r_press_p4 & w_mole_mask);
    assign w_any_press  = |r_press_p4;
    assign w_timer_end  = (r_timer == TIMER_LAST);
    assign w_miss_next  = (r_misses == MISS_MAX) ? r_misses : r_misses + 2'd1;
    assign w_score_next = bcd_inc({r_score_tens, r_score_ones});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_score_tens <= '0;
            r_score_ones <= '0;
            r_misses     <= '0;
            r_timer      <= '0;
            r_hold_cnt   <= '0;
            r_change     <= 1'b0;
            r_hit_flash  <= 1'b0;
        end else begin
            r_change <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (i_start) begin
                        r_state      <= S_PLAY;
                        r_score_tens <= '0;
                        r_score_ones <= '0;
                        r_misses     <= '0;
                        r_timer      <= '0;
                        r_change     <= 1'b1;
                    end
                end
                S_PLAY: begin
                    r_timer <= r_timer + 32'd1;
                    if (w_hit) begin
                        {r_score_tens, r_score_ones} <= w_score_next;
                        r_change <= 1'b1;
                        // A hit on the final timer cycle still scores but ends the game.
                        if (w_timer_end) begin
                            r_state <= S_OVER;
                        end else begin
                            r_state     <= S_HOLD;
                            r_hold_cnt  <= '0;
                            r_hit_flash <= 1'b1;
                        end
                    end else if (w_any_press) begin
                        r_misses <= w_miss_next;
                        if (w_miss_next == MISS_MAX || w_timer_end) r_state <= S_OVER;
                    end else if (w_timer_end) begin
                        r_state <= S_OVER;
                    end
                end
                S_HOLD: begin
                    r_timer <= r_timer + 32'd1;
                    if (w_timer_end) begin
                        r_state     <= S_OVER;
                        r_hit_flash <= 1'b0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= S_PLAY;
                        r_hit_flash <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_change_position = r_change;
    assign o_score_tens      = r_score_tens;
    assign o_score_ones      = r_score_ones;
    assign o_misses          = r_misses;
    assign o_state           = r_state;
    assign o_hit_flash       = r_hit_flash;

endmodule

// File: tb/tb_whack_judge.sv
// Bench for whack_judge: directed scenarios plus randomized press transactions
// checked against a game-level score/miss model.
module tb_whack_judge;

    localparam int D  = 8;
    localparam int G  = 8000;
    localparam int MM = 3;
    localparam int HC = 2;

    logic       i_clk;
    logic       i_rst_n;
    logic [4:0] i_btn;
    logic       i_start;
    logic [2:0] i_mole_position;
    logic       o_change_position;
    logic [3:0] o_score_tens;
    logic [3:0] o_score_ones;
    logic [1:0] o_misses;
    logic [1:0] o_state;
    logic       o_hit_flash;

    whack_judge #(
        .DEBOUNCE_CYCLES(D),
        .GAME_CYCLES    (G),
        .MAX_MISSES     (MM),
        .HOLD_CYCLES    (HC)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_btn            (i_btn),
        .i_start          (i_start),
        .i_mole_position  (i_mole_position),
        .o_change_position(o_change_position),
        .o_score_tens     (o_score_tens),
        .o_score_ones     (o_score_ones),
        .o_misses         (o_misses),
        .o_state          (o_state),
        .o_hit_flash      (o_hit_flash)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pulse_cnt = 0;
    int start_cyc = 0;

    // Game-level reference model
    int m_score  = 0;
    int m_misses = 0;
    int m_pulses = 0;
    bit m_over   = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) if (o_change_position === 1'b1) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    function automatic void model_apply(input logic [4:0] mask, input int mole);
        if (m_over || mask == 5'd0) return;
        if (mole <= 4 && mask[mole]) begin
            if (m_score < 99) m_score++;
            m_pulses++;
        end else begin
            if (m_misses < MM) m_misses++;
            if (m_misses == MM) m_over = 1;
        end
    endfunction

    task automatic start_game();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        start_cyc = cyc;
        m_score = 0; m_misses = 0; m_over = 0;
        m_pulses++;
    endtask

    task automatic press_txn(input logic [4:0] mask, input logic [2:0] mole);
        i_mole_position = mole;
        i_btn = mask;
        tick(D + 8);
        i_btn = 5'd0;
        tick(D + 8);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_btn = 5'd0; i_start = 1'b0; i_mole_position = 3'd7;
        tick(4);
        n_cmp++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h00) begin n_fail++; $display("FAIL reset_score got=%h exp=00", {o_score_tens, o_score_ones}); end
        n_cmp++; if (o_misses !== 2'd0) begin n_fail++; $display("FAIL reset_misses got=%0d exp=0", o_misses); end
        n_cmp++; if (o_change_position !== 1'b0) begin n_fail++; $display("FAIL reset_change got=%b exp=0", o_change_position); end
        n_cmp++; if (o_hit_flash !== 1'b0) begin n_fail++; $display("FAIL reset_flash got=%b exp=0", o_hit_flash); end
        i_rst_n = 1'b1;
        tick(3);
        n_cmp++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL idle_after_release got=%0d exp=0", o_state); end
        n_cmp++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL no_pulse_in_idle got=%0d exp=0", pulse_cnt); end
    endtask

    task automatic test_start();
        start_game();
        n_cmp++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL start_state got=%0d exp=1", o_state); end
        n_cmp++; if (o_change_position !== 1'b1) begin n_fail++; $display("FAIL start_pulse got=%b exp=1", o_change_position); end
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h00) begin n_fail++; $display("FAIL start_score got=%h exp=00", {o_score_tens, o_score_ones}); end
        tick(1);
        n_cmp++; if (o_change_position !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width got=%b exp=0", o_change_position); end
        n_cmp++; if (pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL start_pulse_count got=%0d exp=%0d", pulse_cnt, m_pulses); end
    endtask

    task automatic test_debounce();
        i_mole_position = 3'd2;
        i_btn = 5'd0;
        for (int i = 0; i < 10; i++) begin
            i_btn[2] = ~i_btn[2];
            tick(4);
        end
        n_cmp++; if (o_score_ones !== 4'd0 || o_misses !== 2'd0) begin n_fail++; $display("FAIL bounce_no_event got=%0d/%0d exp=0/0", o_score_ones, o_misses); end
        i_btn[2] = 1'b1;
        tick(D + 3);
        n_cmp++; if (o_score_ones !== 4'd0) begin n_fail++; $display("FAIL debounce_early got=%0d exp=0", o_score_ones); end
        tick(1);
        model_apply(5'b00100, 2);
        n_cmp++; if (o_score_ones !== 4'(m_score % 10)) begin n_fail++; $display("FAIL debounce_hit got=%0d exp=%0d", o_score_ones, m_score % 10); end
        n_cmp++; if (o_change_position !== 1'b1) begin n_fail++; $display("FAIL debounce_pulse got=%b exp=1", o_change_position); end
        i_btn = 5'd0;
        tick(D + 8);
        n_cmp++; if (pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL debounce_pulse_count got=%0d exp=%0d", pulse_cnt, m_pulses); end
    endtask

    task automatic test_hit_priority();
        i_mole_position = 3'd1;
        i_btn = 5'b01010;
        tick(1);
        i_btn = 5'b11010;
        tick(D + 3);
        model_apply(5'b01010, 1);
        n_cmp++; if (o_state !== 2'd2 || o_hit_flash !== 1'b1) begin n_fail++; $display("FAIL hold_entry got=%0d/%b exp=2/1", o_state, o_hit_flash); end
        n_cmp++; if (o_score_ones !== 4'(m_score % 10) || o_misses !== 2'd0) begin n_fail++; $display("FAIL priority_score got=%0d/%0d exp=%0d/0", o_score_ones, o_misses, m_score % 10); end
        tick(1);
        n_cmp++; if (o_state !== 2'd2 || o_hit_flash !== 1'b1) begin n_fail++; $display("FAIL hold_second got=%0d/%b exp=2/1", o_state, o_hit_flash); end
        tick(1);
        n_cmp++; if (o_state !== 2'd1 || o_hit_flash !== 1'b0) begin n_fail++; $display("FAIL hold_exit got=%0d/%b exp=1/0", o_state, o_hit_flash); end
        i_btn = 5'd0;
        tick(D + 8);
        n_cmp++; if (o_misses !== 2'd0) begin n_fail++; $display("FAIL hold_press_discard got=%0d exp=0", o_misses); end
        n_cmp++; if (pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL priority_pulse_count got=%0d exp=%0d", pulse_cnt, m_pulses); end
    endtask

    task automatic test_bcd_saturation();
        while (m_score < 9) begin press_txn(5'b00001, 3'd0); model_apply(5'b00001, 0); end
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h09) begin n_fail++; $display("FAIL bcd_09 got=%h exp=09", {o_score_tens, o_score_ones}); end
        press_txn(5'b00001, 3'd0); model_apply(5'b00001, 0);
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h10) begin n_fail++; $display("FAIL bcd_10 got=%h exp=10", {o_score_tens, o_score_ones}); end
        i_start = 1'b1; tick(1); i_start = 1'b0; tick(1);
        n_cmp++; if (o_state !== 2'd1 || o_score_tens !== 4'd1 || pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL start_ignored got=%0d/%0d/%0d exp=1/1/%0d", o_state, o_score_tens, pulse_cnt, m_pulses); end
        while (m_score < 99) begin press_txn(5'b00001, 3'd0); model_apply(5'b00001, 0); end
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h99) begin n_fail++; $display("FAIL bcd_99 got=%h exp=99", {o_score_tens, o_score_ones}); end
        press_txn(5'b00001, 3'd0); model_apply(5'b00001, 0);
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h99) begin n_fail++; $display("FAIL bcd_sat got=%h exp=99", {o_score_tens, o_score_ones}); end
        n_cmp++; if (pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL sat_pulse_count got=%0d exp=%0d", pulse_cnt, m_pulses); end
    endtask

    task automatic test_miss_over();
        for (int i = 1; i <= MM; i++) begin
            press_txn(5'b00001, 3'd6); model_apply(5'b00001, 6);
            n_cmp++; if (o_misses !== 2'(m_misses) || o_state !== (m_over ? 2'd3 : 2'd1)) begin n_fail++; $display("FAIL miss_%0d got=%0d/%0d exp=%0d/%0d", i, o_misses, o_state, m_misses, m_over ? 3 : 1); end
        end
        press_txn(5'b00001, 3'd0); model_apply(5'b00001, 0);
        press_txn(5'b11111, 3'd6); model_apply(5'b11111, 6);
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h99 || o_misses !== 2'd3 || o_state !== 2'd3) begin n_fail++; $display("FAIL over_frozen got=%h/%0d/%0d exp=99/3/3", {o_score_tens, o_score_ones}, o_misses, o_state); end
        n_cmp++; if (pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL over_no_pulse got=%0d exp=%0d", pulse_cnt, m_pulses); end
    endtask

    task automatic test_restart();
        start_game();
        n_cmp++; if (o_state !== 2'd1 || o_change_position !== 1'b1) begin n_fail++; $display("FAIL restart got=%0d/%b exp=1/1", o_state, o_change_position); end
        n_cmp++; if ({o_score_tens, o_score_ones} !== 8'h00 || o_misses !== 2'd0) begin n_fail++; $display("FAIL restart_clear got=%h/%0d exp=00/0", {o_score_tens, o_score_ones}, o_misses); end
    endtask

    task automatic test_random();
        logic [4:0] mask;
        logic [2:0] mole;
        for (int i = 0; i < 40; i++) begin
            mask = 5'($urandom_range(0, 31));
            mole = 3'($urandom_range(0, 7));
            press_txn(mask, mole);
            model_apply(mask, int'(mole));
            n_cmp++;
            if (o_score_tens !== 4'(m_score / 10) || o_score_ones !== 4'(m_score % 10) ||
                o_misses !== 2'(m_misses) || o_state !== (m_over ? 2'd3 : 2'd1) || pulse_cnt !== m_pulses) begin
                n_fail++;
                $display("FAIL random_%0d mask=%b mole=%0d got=%0d%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         i, mask, mole, o_score_tens, o_score_ones, o_misses, o_state, pulse_cnt,
                         m_score, m_misses, m_over ? 3 : 1, m_pulses);
            end
            if (m_over) start_game();
        end
    endtask

    task automatic test_timer();
        for (int i = 0; i < MM && !m_over; i++) begin press_txn(5'b00001, 3'd7); model_apply(5'b00001, 7); end
        n_cmp++; if (o_state !== 2'd3) begin n_fail++; $display("FAIL timer_setup_over got=%0d exp=3", o_state); end
        start_game();
        i_mole_position = 3'd0;
        while (cyc < start_cyc + G - D - 4) tick(1);
        i_btn = 5'b00001;
        while (cyc < start_cyc + G - 1) tick(1);
        n_cmp++; if (o_state !== 2'd1 || o_score_ones !== 4'd0) begin n_fail++; $display("FAIL timer_pre_end got=%0d/%0d exp=1/0", o_state, o_score_ones); end
        tick(1);
        m_score++; m_pulses++; m_over = 1;
        n_cmp++; if (o_state !== 2'd3) begin n_fail++; $display("FAIL timer_end_state got=%0d exp=3", o_state); end
        n_cmp++; if (o_score_ones !== 4'd1 || o_change_position !== 1'b1) begin n_fail++; $display("FAIL timer_end_hit got=%0d/%b exp=1/1", o_score_ones, o_change_position); end
        i_btn = 5'd0;
        tick(D + 8);
        n_cmp++; if (o_state !== 2'd3 || o_hit_flash !== 1'b0 || pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL timer_after got=%0d/%b/%0d exp=3/0/%0d", o_state, o_hit_flash, pulse_cnt, m_pulses); end
    endtask

    task automatic test_midgame_reset();
        start_game();
        press_txn(5'b00100, 3'd2); model_apply(5'b00100, 2);
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_state !== 2'd0 || {o_score_tens, o_score_ones} !== 8'h00) begin n_fail++; $display("FAIL async_reset got=%0d/%h exp=0/00", o_state, {o_score_tens, o_score_ones}); end
        tick(2);
        i_rst_n = 1'b1;
        tick(4);
        n_cmp++; if (o_state !== 2'd0 || pulse_cnt !== m_pulses) begin n_fail++; $display("FAIL reset_release got=%0d/%0d exp=0/%0d", o_state, pulse_cnt, m_pulses); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_debounce();
        test_hit_priority();
        test_bcd_saturation();
        test_miss_over();
        test_restart();
        test_random();
        test_timer();
        test_midgame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
